// File: rtl/zap_fifo_pkg.sv
// zap_fifo_pkg: shared widths, pointer type and reset flag vector for zap_sync_fifo_lvl.
package zap_fifo_pkg;
   localparam int PTR_IDX_MAX = 16;
   typedef struct packed {
      logic                   wrap;
      logic [PTR_IDX_MAX-1:0] idx;
   } fifo_ptr_t;
   typedef struct packed {
      logic empty;
      logic full;
      logic almost_empty;
      logic almost_full;
   } fifo_flags_t;
   localparam fifo_flags_t FLAGS_RST = '{empty: 1'b1, full: 1'b0, almost_empty: 1'b1, almost_full: 1'b0};
   function automatic int ptr_wdt(input int depth);
      return $clog2(depth) + 1;
   endfunction
   function automatic int lvl_wdt(input int depth);
      return $clog2(depth + 1);
   endfunction
endpackage

// File: rtl/zap_fifo_ptr.sv
// zap_fifo_ptr: FIFO pointer with wrap bit, index wraps at DEPTH-1 (any DEPTH >= 2).
module zap_fifo_ptr
   import zap_fifo_pkg::*;
#(
   parameter int DEPTH = 5
) (
   input  logic      i_clk,
   input  logic      i_reset,
   input  logic      i_clear,
   input  logic      i_inc,
   output fifo_ptr_t o_ptr_ff,
   output fifo_ptr_t o_ptr_nxt
);
   localparam logic [PTR_IDX_MAX-1:0] LAST = PTR_IDX_MAX'(DEPTH - 1);
   localparam logic [PTR_IDX_MAX-1:0] ONE  = PTR_IDX_MAX'(1);
   logic at_last;
   assign at_last = o_ptr_ff.idx == LAST;
   always_comb begin
      o_ptr_nxt = o_ptr_ff;
      if (i_clear) o_ptr_nxt = '0;
      else if (i_inc) begin
         o_ptr_nxt.wrap = o_ptr_ff.wrap ^ at_last;
         o_ptr_nxt.idx  = at_last ? '0 : o_ptr_ff.idx + ONE;
      end
   end
   always_ff @(posedge i_clk or posedge i_reset)
      if (i_reset) o_ptr_ff <= '0;
      else o_ptr_ff <= o_ptr_nxt;
endmodule

// File: rtl/zap_sync_fifo_lvl.sv
// zap_sync_fifo_lvl: sync FIFO, any depth, registered level and watermarks.
// Define ZAP_SYNC_FIFO_ERR_CHECK_EN to add sticky o_overflow/o_underflow.
module zap_sync_fifo_lvl
   import zap_fifo_pkg::*;
#(
   parameter int WIDTH     = 32,
   parameter int DEPTH     = 5,
   parameter int AF_THRESH = DEPTH - 1,
   parameter int AE_THRESH = 1,
   parameter int LVL_W     = lvl_wdt(DEPTH)
) (
   input  logic             i_clk,
   input  logic             i_reset,
   input  logic             i_clear,
   input  logic             i_wr_en,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_ack,
`ifdef ZAP_SYNC_FIFO_ERR_CHECK_EN
   output logic             o_overflow,
   output logic             o_underflow,
`endif
   output logic [WIDTH-1:0] o_data,
   output logic             o_empty,
   output logic             o_empty_n,
   output logic             o_full,
   output logic             o_full_n,
   output logic [LVL_W-1:0] o_level,
   output logic             o_almost_full,
   output logic             o_almost_empty
);
   localparam int IW = ptr_wdt(DEPTH) - 1;
   localparam logic [LVL_W-1:0] AF = LVL_W'(AF_THRESH);
   localparam logic [LVL_W-1:0] AE = LVL_W'(AE_THRESH);
   logic             wr_ok, rd_ok, unused_ptr;
   fifo_ptr_t        rd_ff, rd_nxt, wr_ff, wr_nxt;
   fifo_flags_t      flg, flg_nxt;
   logic [LVL_W-1:0] lvl_nxt;
   logic [WIDTH-1:0] mem [DEPTH];
   assign wr_ok = i_wr_en & ~o_full;
   assign rd_ok = i_ack & ~o_empty;
   zap_fifo_ptr #(.DEPTH(DEPTH)) u_rd_ptr (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_clear   (i_clear),
      .i_inc     (rd_ok),
      .o_ptr_ff  (rd_ff),
      .o_ptr_nxt (rd_nxt)
   );
   zap_fifo_ptr #(.DEPTH(DEPTH)) u_wr_ptr (
      .i_clk     (i_clk),
      .i_reset   (i_reset),
      .i_clear   (i_clear),
      .i_inc     (wr_ok),
      .o_ptr_ff  (wr_ff),
      .o_ptr_nxt (wr_nxt)
   );
   // Only the low index bits address storage; wrap and spare bits feed the flags.
   assign unused_ptr = ^{rd_ff, wr_ff};
   assign lvl_nxt = i_clear ? '0 : o_level + LVL_W'(wr_ok) - LVL_W'(rd_ok);
   always_comb begin
      flg_nxt.empty        = rd_nxt == wr_nxt;
      flg_nxt.full         = (rd_nxt.idx == wr_nxt.idx) & (rd_nxt.wrap != wr_nxt.wrap);
      flg_nxt.almost_empty = lvl_nxt <= AE;
      flg_nxt.almost_full  = lvl_nxt >= AF;
   end
   always_ff @(posedge i_clk or posedge i_reset)
      if (i_reset) begin
         o_level <= '0;
         flg     <= FLAGS_RST;
      end else begin
         o_level <= lvl_nxt;
         flg     <= flg_nxt;
      end
   always_ff @(posedge i_clk)
      if (wr_ok & ~i_clear) mem[wr_ff.idx[IW-1:0]] <= i_data;
   assign o_data         = mem[rd_ff.idx[IW-1:0]];
   assign o_empty        = flg.empty;
   assign o_empty_n      = ~flg.empty;
   assign o_full         = flg.full;
   assign o_full_n       = ~flg.full;
   assign o_almost_empty = flg.almost_empty;
   assign o_almost_full  = flg.almost_full;
`ifdef ZAP_SYNC_FIFO_ERR_CHECK_EN
   always_ff @(posedge i_clk or posedge i_reset)
      if (i_reset) begin
         o_overflow  <= 1'b0;
         o_underflow <= 1'b0;
      end else if (i_clear) begin
         o_overflow  <= 1'b0;
         o_underflow <= 1'b0;
      end else begin
         o_overflow  <= o_overflow | (i_wr_en & o_full);
         o_underflow <= o_underflow | (i_ack & o_empty);
      end
`ifndef SYNTHESIS
   always_ff @(posedge i_clk)
      if (!i_reset && !i_clear) begin
         ovf_chk: assert (!(i_wr_en && o_full)) else $warning("zap_sync_fifo_lvl overflow");
         udf_chk: assert (!(i_ack && o_empty)) else $warning("zap_sync_fifo_lvl underflow");
      end
`endif
`endif
endmodule

// File: doc/zap_sync_fifo_lvl.md
Name: zap_sync_fifo_lvl

Overview:
Parametrised synchronous FIFO and the next generation of the existing sync FIFO. Adds non-power-of-two depth, a registered occupancy count, and registered almost-full/almost-empty watermarks. Serves as a general buffer between the core pipeline, the cache/TLB fill paths and the bus interface, where producers need early back-pressure.

Parameters:
WIDTH, 32, data word width in bits (>=1).
DEPTH, 5, number of storage entries (>=2; need not be a power of two).
AF_THRESH, DEPTH-1, o_almost_full asserts when level >= AF_THRESH (1..DEPTH).
AE_THRESH, 1, o_almost_empty asserts when level <= AE_THRESH (0..DEPTH-1).

Ports:
i_clk  in  1  clock, all flops on rising edge.
i_reset  in  1  asynchronous, active-high reset.
i_clear  in  1  synchronous flush.
i_wr_en  in  1  write request.
i_data  in  WIDTH  write data.
i_ack  in  1  read request; pops the head entry.
o_data  out  WIDTH  head entry; valid when o_empty=0.
o_empty / o_empty_n  out  1  registered empty flag and its complement.
o_full / o_full_n  out  1  registered full flag and its complement.
o_level  out  LVL_W  registered occupancy, 0..DEPTH; LVL_W = $clog2(DEPTH+1).
o_almost_full  out  1  registered, level >= AF_THRESH.
o_almost_empty  out  1  registered, level <= AE_THRESH.

Behaviour:
- Reset is asynchronous and active-high on a single clock i_clk: this is fixed.
- Reset values: pointers 0, o_level 0, o_empty 1, o_full 0, o_almost_empty 1, o_almost_full 0. Memory is not reset, so o_data is X or stale until the first write.
- Reset mid-operation discards all contents immediately. The first write after reset release is accepted normally.
- write_ok = i_wr_en & ~o_full. read_ok = i_ack & ~o_empty. A blocked request is a no-op; no state changes.
- Pointers: index 0..DEPTH-1 plus a wrap bit. On increment at DEPTH-1, the index goes to 0 and the wrap bit toggles.
- Empty: indices equal and wrap bits equal. Full: indices equal and wrap bits differ.
- Level: next = level + write_ok - read_ok. Level is held as a register and is not derived from pointer subtraction.
- All flags are computed from next-state values and registered, so they reflect state one cycle after the accepting edge.
- Write latency: data written at edge N is visible on o_data with o_empty=0 after edge N.
- o_data is a combinational read at the read index, same as the existing FIFO (zero-latency head).
- Simultaneous write and read when neither empty nor full: both proceed and the level is unchanged.
- When full, the write is blocked even if a read occurs in the same cycle (no bypass).
- When empty, the read is blocked even if a write occurs in the same cycle (no fall-through).
- i_clear takes priority over i_wr_en and i_ack in the same cycle. Its next state equals the reset state.

Optional Feature:
ZAP_SYNC_FIFO_ERR_CHECK_EN
- Defined: adds outputs o_overflow and o_underflow, each 1 bit, sticky, reset/clear to 0.
  - o_overflow sets when i_wr_en & o_full.
  - o_underflow sets when i_ack & o_empty.
  - Both are registered. Simulation builds additionally fire an immediate assertion on each event.
- Undefined: both ports are absent and there is no extra logic. All other behaviour is identical.

Decomposition:
- Package zap_fifo_pkg:
  - function ptr_wdt(depth) = $clog2(depth)+1 and function lvl_wdt(depth) = $clog2(depth+1);
  - typedef for the {wrap, index} pointer struct;
  - constant for the reset flag vector.
- Sub-module zap_fifo_ptr:
  - parameter DEPTH;
  - inputs i_clk, i_reset, i_clear, i_inc;
  - outputs o_ptr_ff and o_ptr_nxt;
  - implements non-power-of-two wrap.
  - Instantiated twice, once for the read pointer and once for the write pointer.

Test Plan (DEPTH=5, WIDTH=8, AF_THRESH=4, AE_THRESH=1):
1. After reset, write 0x11..0x55 on 5 consecutive cycles. After each write, level reads 1,2,3,4,5. o_almost_empty deasserts at level 2, o_almost_full asserts at level 4, o_full=1 after the 5th write. A 6th write of 0x66 is ignored and level stays 5.
2. Pop all 5 entries. o_data sequence is 0x11,0x22,0x33,0x44,0x55. o_empty=1 after the last pop. A further i_ack leaves level at 0.
3. Wrap: run 13 write/read pairs with one entry resident. Data stays in order across the index 4->0 wrap, and the wrap bit toggles each lap. o_full never asserts.
4. At level 3, assert i_wr_en and i_ack together. Level stays 3, the head advances, and the new data appears at the tail.
5. At level 4, assert i_clear with i_wr_en=1 and i_ack=1. Next cycle: level 0, o_empty=1, o_almost_empty=1, o_almost_full=0, and nothing was written.
6. Assert i_reset asynchronously mid-clock at level 3. Flags take reset values before the next edge. With ERR_CHECK_EN defined, a write when full sets o_overflow, which stays set until i_clear.
